// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and defaults for the 4-way round-robin mux arbiter.
// State encoding plus the one-hot helper used by the grant path.
package mux4_rr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int MAX_HOLD_DEF = 4;

   function automatic logic [3:0] onehot4(input logic [1:0] s);
      return 4'b0001 << s;
   endfunction

endpackage

// File: rtl/mux4_rr_pick4.sv
// Rotating-priority picker: first set req bit at or above ptr, mod 4.
// Purely combinational; shared by the idle and release paths.
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] winner,
   output logic       found
);

   // scan from the farthest offset down so the nearest hit wins
   always_comb begin
      logic [1:0] idx;
      winner = 2'd0;
      found  = 1'b0;
      idx    = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data channel among four requesters.
// Grants are held for up to MAX_HOLD accepted beats, then rotate.
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic             out_ready,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             busy
);

   localparam int CW = $clog2(MAX_HOLD) + 1;
   localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

   arb_state_e    state_q, state_d;
   logic [3:0]    gnt_q, gnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [1:0] pick_ptr;
   logic [1:0] winner;
   logic       found;
   logic       beat;
   logic       release_g;

   // data mux follows the registered select
   always_comb begin
      out_data = sel_q[1] ? (sel_q[0] ? i3 : i2)
                          : (sel_q[0] ? i1 : i0);
   end

   assign out_valid = gnt_q[sel_q] & req[sel_q];
   assign beat      = out_valid & out_ready;
   assign busy      = (state_q == GRANT);
   assign gnt       = gnt_q;
   assign sel       = sel_q;

   // on release the search starts just past the current owner
   assign pick_ptr  = busy ? sel_q + 2'd1 : ptr_q;
   assign release_g = !req[sel_q] | (beat & (cnt_q == LAST));

   rr_pick4 u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .winner (winner),
      .found  (found)
   );

   // next-state: grant on idle request, hold/count, rotate on release
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               state_d = GRANT;
               gnt_d   = onehot4(winner);
               sel_d   = winner;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (release_g) begin
               ptr_d = sel_q + 2'd1;
               cnt_d = '0;
               if (found) begin
                  gnt_d = onehot4(winner);
                  sel_d = winner;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
               end
            end else if (beat) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   // state registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'b00;
         ptr_q   <= 2'b00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 data channel among four requesters.
- Grants one requester at a time and drives the 2-bit mux select (s1 = sel[1], s0 = sel[0]).
- Holds the grant for a bounded burst of beats, then rotates.
- Sits between four producer ports and a single downstream consumer with a ready handshake.

Parameters:
- WIDTH, 8, data width of each requester input and of out_data.
- MAX_HOLD, 4, maximum beats per grant before forced rotation; legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request per requester; bit n = requester n.
- i0  input  WIDTH  data from requester 0.
- i1  input  WIDTH  data from requester 1.
- i2  input  WIDTH  data from requester 2.
- i3  input  WIDTH  data from requester 3.
- out_ready  input  1  downstream accepts a beat this cycle.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  registered mux select; sel[1] = s1, sel[0] = s0.
- out_data  output  WIDTH  selected data.
- out_valid  output  1  beat present on out_data.
- busy  output  1  high while in GRANT state.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset values:
  - state = IDLE; gnt = 4'b0000; sel = 2'b00; busy = 0.
  - ptr = 0 (priority pointer, 2 bits); beat_cnt = 0.
  - out_valid = 0 (follows from gnt = 0).
- Combinational outputs:
  - out_data = i[sel] at all times.
  - out_valid = gnt[sel] & req[sel].
  - beat = out_valid & out_ready.
- Winner search: scan req starting at index ptr, upward mod 4. The first set bit wins.
- IDLE state:
  - If req != 0: next cycle state = GRANT, gnt = onehot(winner), sel = winner, beat_cnt = 0.
  - Otherwise remain IDLE; gnt stays 0; sel holds its last value.
  - Latency from req rising to gnt is 1 clock.
- GRANT state:
  - On each beat, beat_cnt increments.
  - release = !req[sel] OR (beat AND beat_cnt == MAX_HOLD-1).
  - If no release, hold gnt, sel and state.
- On release, in the same edge:
  - ptr = sel+1 (mod 4).
  - Winner search runs on current req with ptr' = sel+1.
  - If a winner exists: gnt/sel switch to it, beat_cnt = 0, state stays GRANT. There is no idle bubble.
  - If no winner: state = IDLE, gnt = 0.
- Current requester after forced release: it is searched last. It is re-granted only if it is the sole requester.
- req dropping while not ready: release occurs without a beat, and beat_cnt is discarded.
- Boundary cases:
  - MAX_HOLD = 1: rotation after every accepted beat.
  - beat_cnt never exceeds MAX_HOLD-1; width is clog2(MAX_HOLD)+1.
  - Beats with out_ready = 0 do not count; the grant holds indefinitely while req[sel] stays high and the consumer stalls.
  - Requests from non-granted requesters are ignored until release. No preemption.
  - reset asserted mid-burst: all state returns to reset values immediately (asynchronously). out_valid drops in the same cycle.
- Invariants: gnt is always zero or one-hot, and gnt == onehot(sel) whenever busy = 1.

Decomposition:
- Shared package/header holds the state encodings IDLE = 1'b0, GRANT = 1'b1 and the default for MAX_HOLD.
- One sub-module: rr_pick4.
  - Combinational; inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and found.
  - Reused in both the IDLE and release paths.
- The data mux is inline in the top level, using the same conditional selection as the team's 4:1 mux.

Test Plan:
- Reset then idle: reset pulse, req = 0 for 5 cycles -> gnt = 0000, sel = 00, busy = 0, out_valid = 0 throughout.
- Single requester: req = 0100, out_ready = 1, i2 = 8'hA5 -> one cycle later gnt = 0100, sel = 10, out_data = A5, out_valid = 1. After 4 beats gnt is re-granted to 0100, with no gap.
- Rotation: req = 1111 held, out_ready = 1, MAX_HOLD = 4 -> grant order 0, 1, 2, 3, 0, each held exactly 4 cycles, no idle cycles.
- Early release: req = 0011, requester 0 granted, req[0] drops after 2 beats -> next edge gnt = 0010, beat_cnt = 0, ptr = 1.
- Stall: granted requester 3, out_ready = 0 for 10 cycles, then 1 -> gnt holds 1000 for all 10 stall cycles, then releases after 4 accepted beats.
- Async reset mid-burst: reset asserted between edges during a grant to requester 1 -> gnt = 0000 and out_valid = 0 immediately. After reset release, with req = 0010, requester 1 is granted again one cycle later with ptr = 0 search.
